// File: rtl/traffic_lights_pkg.sv
// Shared types for the traffic-light controller, its command sequencer and benches.
package traffic_lights_pkg;

   typedef enum logic [2:0] {
      CMD_ON     = 3'd0,
      CMD_OFF    = 3'd1,
      CMD_BLINK  = 3'd2,
      CMD_GREEN  = 3'd3,
      CMD_YELLOW = 3'd4,
      CMD_RED    = 3'd5
   } cmd_type_t;

   typedef enum logic [1:0] {
      MODE_RUN   = 2'd0,
      MODE_OFF   = 2'd1,
      MODE_BLINK = 2'd2
   } mode_t;

   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_BLINK  = 3'd1,
      S_RED    = 3'd2,
      S_GREEN  = 3'd3,
      S_YELLOW = 3'd4
   } seq_state_t;

   // A zero-length phase would stall the controller, so 0 ms is treated as 1 ms.
   function automatic logic [15:0] clamp_ms(input logic [15:0] ms);
      return (ms == 16'd0) ? 16'd1 : ms;
   endfunction

endpackage

// File: rtl/traffic_lights_cmd_seq_if.sv
// Host request side and controller command side of the sequencer.
interface traffic_lights_cmd_seq_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [1:0]  req_mode_i;
   logic [15:0] cfg_red_ms_i;
   logic [15:0] cfg_green_ms_i;
   logic [15:0] cfg_yel_ms_i;
   logic [2:0]  cmd_type_o;
   logic        cmd_valid_o;
   logic [15:0] cmd_data_o;
   logic [2:0]  phase_o;

   // master: host/bench side; slave: the sequencer itself
   modport master (
      output req_valid_i, req_mode_i, cfg_red_ms_i, cfg_green_ms_i, cfg_yel_ms_i,
      input  req_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, phase_o
   );

   modport slave (
      input  req_valid_i, req_mode_i, cfg_red_ms_i, cfg_green_ms_i, cfg_yel_ms_i,
      output req_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, phase_o
   );
endinterface

// File: rtl/tl_phase_timer.sv
// Phase down-counter: load W-1, count to zero, then hold and flag expiry until reloaded or stopped.
module tl_phase_timer (
   input  logic        clk,
   input  logic        srst_n,
   input  logic        load,
   input  logic        stop,
   input  logic [31:0] load_value,
   output logic        expire
);
   logic [31:0] count_reg;
   logic        run_reg;

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         count_reg <= '0;
         run_reg   <= 1'b0;
      end else if (stop) begin
         count_reg <= '0;
         run_reg   <= 1'b0;
      end else if (load) begin
         count_reg <= load_value;
         run_reg   <= 1'b1;
      end else if (run_reg && (count_reg != 32'd0)) begin
         count_reg <= count_reg - 32'd1;
      end
   end

   // Holding at zero means a discarded expiry simply re-fires next cycle.
   assign expire = run_reg && (count_reg == 32'd0);

endmodule

// File: rtl/traffic_lights_cmd_seq.sv
// Turns host mode requests into the timed one-cycle command stream for the light controller.
module traffic_lights_cmd_seq
   import traffic_lights_pkg::*;
#(
   parameter int TICKS_PER_MS = 2,
   parameter int STATE_RY_MS  = 3,
   parameter int G_BLINK_T    = 4,
   parameter int GUARD_CYC    = 2
) (
   input  logic                   clk_i,
   input  logic                   srst_n_i,
   traffic_lights_cmd_seq_if.slave bus
);
   localparam logic [31:0] TPM       = 32'(TICKS_PER_MS);
   localparam logic [31:0] RED_EXTRA = 32'(STATE_RY_MS * TICKS_PER_MS + GUARD_CYC);
   localparam logic [31:0] GRN_EXTRA = 32'(G_BLINK_T + GUARD_CYC);
   localparam logic [31:0] YEL_EXTRA = 32'(GUARD_CYC);

   // Timer reload for a phase of `ms` milliseconds plus fixed controller overhead.
   function automatic logic [31:0] reload(input logic [15:0] ms, input logic [31:0] extra);
      return ({16'd0, ms} * TPM) + extra - 32'd1;
   endfunction

   seq_state_t  state_reg, state_next;
   cmd_type_t   cmd_type_reg, cmd_type_next;
   logic [15:0] cmd_data_reg, cmd_data_next;
   logic        cmd_valid_reg, cmd_valid_next;
   logic [15:0] red_reg, red_next;
   logic [15:0] green_reg, green_next;
   logic [15:0] yel_reg, yel_next;

   logic [15:0] red_in, green_in, yel_in;
   logic        accept;
   logic        tmr_load, tmr_stop, tmr_expire;
   logic [31:0] tmr_value;

   assign red_in   = clamp_ms(bus.cfg_red_ms_i);
   assign green_in = clamp_ms(bus.cfg_green_ms_i);
   assign yel_in   = clamp_ms(bus.cfg_yel_ms_i);

   assign bus.req_ready_o = srst_n_i && !cmd_valid_reg;
   assign accept          = bus.req_valid_i && bus.req_ready_o;

   assign bus.cmd_type_o  = cmd_type_reg;
   assign bus.cmd_valid_o = cmd_valid_reg;
   assign bus.cmd_data_o  = cmd_data_reg;
   assign bus.phase_o     = state_reg;

   tl_phase_timer u_timer (
      .clk        (clk_i),
      .srst_n     (srst_n_i),
      .load       (tmr_load),
      .stop       (tmr_stop),
      .load_value (tmr_value),
      .expire     (tmr_expire)
   );

   always_comb begin
      state_next     = state_reg;
      cmd_type_next  = cmd_type_reg;
      cmd_data_next  = cmd_data_reg;
      cmd_valid_next = 1'b0;
      red_next       = red_reg;
      green_next     = green_reg;
      yel_next       = yel_reg;
      tmr_load       = 1'b0;
      tmr_stop       = 1'b0;
      tmr_value      = '0;

      // An accepted request always beats a same-cycle timer expiry.
      if (accept) begin
         red_next   = red_in;
         green_next = green_in;
         yel_next   = yel_in;
         case (bus.req_mode_i)
            MODE_OFF: begin
               cmd_valid_next = 1'b1;
               cmd_type_next  = CMD_OFF;
               state_next     = S_OFF;
               tmr_stop       = 1'b1;
            end
            MODE_BLINK: begin
               cmd_valid_next = 1'b1;
               cmd_type_next  = CMD_BLINK;
               state_next     = S_BLINK;
               tmr_stop       = 1'b1;
            end
            MODE_RUN: begin
               if ((state_reg == S_OFF) || (state_reg == S_BLINK)) begin
                  cmd_valid_next = 1'b1;
                  cmd_type_next  = CMD_ON;
                  cmd_data_next  = red_in;
                  state_next     = S_RED;
                  tmr_load       = 1'b1;
                  tmr_value      = reload(red_in, RED_EXTRA);
               end
            end
            default: ;
         endcase
      end else if (tmr_expire) begin
         case (state_reg)
            S_RED: begin
               cmd_valid_next = 1'b1;
               cmd_type_next  = CMD_GREEN;
               cmd_data_next  = green_reg;
               state_next     = S_GREEN;
               tmr_load       = 1'b1;
               tmr_value      = reload(green_reg, GRN_EXTRA);
            end
            S_GREEN: begin
               cmd_valid_next = 1'b1;
               cmd_type_next  = CMD_YELLOW;
               cmd_data_next  = yel_reg;
               state_next     = S_YELLOW;
               tmr_load       = 1'b1;
               tmr_value      = reload(yel_reg, YEL_EXTRA);
            end
            S_YELLOW: begin
               cmd_valid_next = 1'b1;
               cmd_type_next  = CMD_RED;
               cmd_data_next  = red_reg;
               state_next     = S_RED;
               tmr_load       = 1'b1;
               tmr_value      = reload(red_reg, RED_EXTRA);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         state_reg     <= S_OFF;
         cmd_type_reg  <= CMD_OFF;
         cmd_data_reg  <= 16'd0;
         cmd_valid_reg <= 1'b0;
         red_reg       <= 16'd1;
         green_reg     <= 16'd1;
         yel_reg       <= 16'd1;
      end else begin
         state_reg     <= state_next;
         cmd_type_reg  <= cmd_type_next;
         cmd_data_reg  <= cmd_data_next;
         cmd_valid_reg <= cmd_valid_next;
         red_reg       <= red_next;
         green_reg     <= green_next;
         yel_reg       <= yel_next;
      end
   end

endmodule
